// File: rtl/sb_pkg.sv
// Shared types for the store buffer: FIFO entry, drain FSM states, overlap window.
package sb_pkg;

    localparam int SB_ADDR_W        = 64;
    localparam int SB_DATA_W        = 64;
    localparam int SB_OVERLAP_BYTES = 8;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

    typedef enum logic [0:0] {
        DR_IDLE  = 1'b0,
        DR_WRITE = 1'b1
    } dr_state_t;

endpackage

// File: rtl/store_buffer_if.sv
// MEM-stage store/load ports and data-memory write port of the store buffer.
interface store_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              St_Valid;
    logic [ADDR_W-1:0] St_Addr;
    logic [DATA_W-1:0] St_Data;
    logic              St_Ready;
    logic              Ld_Valid;
    logic [ADDR_W-1:0] Ld_Addr;
    logic              Ld_Hit;
    logic [DATA_W-1:0] Ld_Fwd_Data;
    logic              Ld_Stall;
    logic              Mem_Busy;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [DATA_W-1:0] Write_Data;
    logic              Mem_Write;
    logic [CNT_W-1:0]  Count;
    logic              Empty;

    modport master (
        output St_Valid, St_Addr, St_Data, Ld_Valid, Ld_Addr, Mem_Busy,
        input  St_Ready, Ld_Hit, Ld_Fwd_Data, Ld_Stall, Mem_Addr, Write_Data,
               Mem_Write, Count, Empty
    );

    modport slave (
        input  St_Valid, St_Addr, St_Data, Ld_Valid, Ld_Addr, Mem_Busy,
        output St_Ready, Ld_Hit, Ld_Fwd_Data, Ld_Stall, Mem_Addr, Write_Data,
               Mem_Write, Count, Empty
    );

endinterface

// File: rtl/sb_match.sv
// Combinational address compare of one buffered store against the load address.
module sb_match
    import sb_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic              vld,
    input  logic [ADDR_W-1:0] ent_addr,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              exact,
    output logic              partial
);
    logic [ADDR_W-1:0] d_fwd, d_bwd;

    // Modular differences, so accesses straddling address wrap still overlap.
    assign d_fwd   = ld_addr - ent_addr;
    assign d_bwd   = ent_addr - ld_addr;
    assign exact   = vld && (ent_addr == ld_addr);
    assign partial = vld && (ent_addr != ld_addr) &&
                     ((d_fwd < ADDR_W'(SB_OVERLAP_BYTES)) ||
                      (d_bwd < ADDR_W'(SB_OVERLAP_BYTES)));

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order drain FIFO with load overlap detection.
// STORE_FWD_EN enables youngest-exact-match forwarding; otherwise any overlap stalls.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input logic           clk,
    input logic           reset,
    store_buffer_if.slave sb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t        slot_q [DEPTH];
    sb_entry_t        out_q;
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] cnt_q;
    dr_state_t        state_q;

    logic st_ready, push, pop;

    // Full check ignores a same-cycle pop.
    assign st_ready = (cnt_q != CNT_W'(DEPTH));
    assign push     = sb.St_Valid && st_ready;
    assign pop      = (cnt_q != '0) && !sb.Mem_Busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            state_q <= DR_IDLE;
            out_q   <= '0;
        end else begin
            if (push) tail_q <= tail_q + PTR_W'(1);
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
                out_q  <= slot_q[head_q];
            end
            state_q <= pop ? DR_WRITE : DR_IDLE;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Slot storage needs no reset: validity comes from head/count.
    always_ff @(posedge clk) begin
        if (push) begin
            slot_q[tail_q].addr <= sb.St_Addr;
            slot_q[tail_q].data <= sb.St_Data;
        end
    end

    assign sb.St_Ready   = st_ready;
    assign sb.Mem_Write  = (state_q == DR_WRITE);
    assign sb.Mem_Addr   = out_q.addr;
    assign sb.Write_Data = out_q.data;
    assign sb.Count      = cnt_q;
    assign sb.Empty      = (cnt_q == '0) && (state_q == DR_IDLE);

    // Index DEPTH is the in-flight register; 0..DEPTH-1 are FIFO slots.
    logic [DEPTH:0]   exact, partial;
    logic [DEPTH-1:0] slot_vld;

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_slot
            logic [PTR_W-1:0] age;
            assign age         = PTR_W'(i) - head_q;
            assign slot_vld[i] = ({1'b0, age} < cnt_q);
            sb_match #(.ADDR_W(ADDR_W)) u_match (
                .vld     (slot_vld[i]),
                .ent_addr(slot_q[i].addr),
                .ld_addr (sb.Ld_Addr),
                .exact   (exact[i]),
                .partial (partial[i])
            );
        end
    endgenerate

    sb_match #(.ADDR_W(ADDR_W)) u_match_infl (
        .vld     (state_q == DR_WRITE),
        .ent_addr(out_q.addr),
        .ld_addr (sb.Ld_Addr),
        .exact   (exact[DEPTH]),
        .partial (partial[DEPTH])
    );

    logic any_exact, any_partial;
    assign any_exact   = |exact;
    assign any_partial = |partial;

`ifdef STORE_FWD_EN
    logic [DATA_W-1:0] fwd_data;
    logic [PTR_W-1:0]  idx;

    // Walk oldest to youngest; the last exact match wins.
    always_comb begin
        fwd_data = '0;
        idx      = '0;
        if (exact[DEPTH]) fwd_data = out_q.data;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if (exact[idx]) fwd_data = slot_q[idx].data;
        end
    end

    assign sb.Ld_Hit      = sb.Ld_Valid && any_exact && !any_partial;
    assign sb.Ld_Stall    = sb.Ld_Valid && any_partial;
    assign sb.Ld_Fwd_Data = sb.Ld_Hit ? fwd_data : '0;
`else
    assign sb.Ld_Hit      = 1'b0;
    assign sb.Ld_Stall    = sb.Ld_Valid && (any_exact || any_partial);
    assign sb.Ld_Fwd_Data = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios then random traffic vs a queue model.
module tb_store_buffer;
    localparam int DEPTH = 4;
`ifdef STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    store_buffer_if #(.DEPTH(DEPTH), .ADDR_W(64), .DATA_W(64)) sbif ();
    store_buffer #(.DEPTH(DEPTH), .ADDR_W(64), .DATA_W(64)) dut (
        .clk  (clk),
        .reset(reset),
        .sb   (sbif)
    );

    // Byte-addressed data memory written by the DUT's drain port.
    logic [7:0] mem [logic [63:0]];
    always @(negedge clk)
        if (sbif.Mem_Write)
            for (int b = 0; b < 8; b++)
                mem[sbif.Mem_Addr + 64'(b)] = sbif.Write_Data[8*b +: 8];

    typedef struct {
        logic [63:0] a;
        logic [63:0] d;
    } ent_t;

    ent_t q[$];
    ent_t infl;
    bit   infl_v;
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit overlaps(input logic [63:0] e, input logic [63:0] l);
        logic [63:0] d1, d2;
        d1 = l - e;
        d2 = e - l;
        return (e != l) && ((d1 < 64'd8) || (d2 < 64'd8));
    endfunction

    // Drive one cycle, check outputs against the model, then advance the model at the edge.
    task automatic step(input bit sv, input logic [63:0] sa, input logic [63:0] sd,
                        input bit lv, input logic [63:0] la, input bit busy, input bit rs);
        bit          ex, pa, push, e_hit, e_stall;
        logic [63:0] fd;
        ent_t        e;
        @(negedge clk);
        sbif.St_Valid = sv; sbif.St_Addr = sa; sbif.St_Data = sd;
        sbif.Ld_Valid = lv; sbif.Ld_Addr = la; sbif.Mem_Busy = busy;
        reset = rs;
        #1;
        ex = 0; pa = 0; fd = '0;
        if (infl_v) begin
            if (infl.a == la) begin ex = 1; fd = infl.d; end
            else if (overlaps(infl.a, la)) pa = 1;
        end
        foreach (q[k]) begin
            if (q[k].a == la) begin ex = 1; fd = q[k].d; end
            else if (overlaps(q[k].a, la)) pa = 1;
        end
        e_hit   = lv && FWD && ex && !pa;
        e_stall = lv && (FWD ? pa : (ex || pa));
        chk("count",    64'(sbif.Count),    64'(q.size()));
        chk("st_ready", 64'(sbif.St_Ready), 64'(q.size() < DEPTH));
        chk("empty",    64'(sbif.Empty),    64'(q.size() == 0 && !infl_v));
        chk("mem_wr",   64'(sbif.Mem_Write), 64'(infl_v));
        if (infl_v) begin
            chk("mem_addr", sbif.Mem_Addr,   infl.a);
            chk("wr_data",  sbif.Write_Data, infl.d);
        end
        chk("ld_hit",   64'(sbif.Ld_Hit),   64'(e_hit));
        chk("ld_stall", 64'(sbif.Ld_Stall), 64'(e_stall));
        chk("ld_fwd",   sbif.Ld_Fwd_Data,   e_hit ? fd : 64'd0);
        @(posedge clk);
        if (rs) begin
            q.delete();
            infl_v = 0;
        end else begin
            push = sv && (q.size() < DEPTH);
            if (q.size() > 0 && !busy) begin
                infl   = q.pop_front();
                infl_v = 1;
            end else infl_v = 0;
            if (push) begin
                e.a = sa; e.d = sd;
                q.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [63:0] rd;
        reset = 1'b1;
        sbif.St_Valid = 0; sbif.St_Addr = 0; sbif.St_Data = 0;
        sbif.Ld_Valid = 0; sbif.Ld_Addr = 0; sbif.Mem_Busy = 0;
        infl_v = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_addr", sbif.Mem_Addr, 64'd0);
        chk("rst_wr_data",  sbif.Write_Data, 64'd0);
        chk("rst_count",    64'(sbif.Count), 64'd0);

        // Single store, then read it back from memory
        step(1, 64'd16, 64'h55, 0, 0, 0, 0);
        idle(3);
        for (int b = 0; b < 8; b++)
            rd[8*b +: 8] = mem.exists(64'd16 + 64'(b)) ? mem[64'd16 + 64'(b)] : 8'hxx;
        chk("mem_rd16", rd, 64'h55);

        // Fill under backpressure, rejected 5th store, then drain in order
        step(1, 64'd0,  64'h100, 0, 0, 1, 0);
        step(1, 64'd8,  64'h108, 0, 0, 1, 0);
        step(1, 64'd24, 64'h118, 0, 0, 1, 0);
        step(1, 64'd32, 64'h120, 0, 0, 1, 0);
        step(1, 64'd48, 64'h130, 0, 0, 1, 0);
        chk("full_count", 64'(sbif.Count), 64'd4);
        idle(6);

        // Two stores to the same address, load picks the youngest
        step(1, 64'd40, 64'hA, 0, 0, 1, 0);
        step(1, 64'd40, 64'hB, 0, 0, 1, 0);
        step(0, 0, 0, 1, 64'd40, 1, 0);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 64'd40, 0, 0);

        // Partial overlap stalls until the write to 8 completes
        step(1, 64'd8, 64'h77, 0, 0, 1, 0);
        step(0, 0, 0, 1, 64'd12, 1, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 64'd12, 0, 0);

        // Reset with three stores buffered
        step(1, 64'd64, 64'h1, 0, 0, 1, 0);
        step(1, 64'd72, 64'h2, 0, 0, 1, 0);
        step(1, 64'd80, 64'h3, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(4);

        // Random traffic over a narrow address range to provoke overlaps
        for (int n = 0; n < 400; n++) begin
            logic [63:0] sa, la, sd;
            sa = 64'($urandom_range(0, 15)) * 64'd4;
            la = 64'($urandom_range(0, 15)) * 64'd4;
            sd = {$urandom, $urandom};
            step($urandom_range(0, 1) == 1, sa, sd, $urandom_range(0, 1) == 1, la,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);
        end
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
